// File: rtl/riscv_fdq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_fdq_pkg
// Description : Shared types and constants for the fetch-to-decode
//               instruction queue: the stored entry layout and the bit
//               positions of the decode-side instruction slices.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_fdq_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int ILEN_DEF  = 32;

    // Field positions inside a 32-bit RISC-V instruction
    localparam int RS1_LSB   = 15;
    localparam int IMM12_LSB = 20;

    // One queued fetch packet; the illegal flag rides with its instruction
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN_DEF-1:0] inst;
        logic [XLEN_DEF-1:0] pcplus4;
        logic                cillegal;
    } fdq_entry_t;

endpackage
`default_nettype wire

// File: rtl/riscv_fdq_ptr.sv
`default_nettype none
// ============================================================================
// Module      : riscv_fdq_ptr
// Description : Pointer and occupancy bookkeeping for the F/D queue.
//               Qualifies push/pop requests, tracks write/read pointers
//               and entry count, and produces full/empty.
// Ports       : i_riscv_fdq_clk / i_riscv_fdq_rst   clock, async reset
//               i_riscv_fdq_flush                   sync clear
//               i_riscv_fdq_push_req / pop_req      fetch valid / decode ready
//               o_riscv_fdq_push / pop              qualified handshakes
//               o_riscv_fdq_wr_ptr / rd_ptr         storage indices
//               o_riscv_fdq_count / full / empty    occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_fdq_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                       i_riscv_fdq_clk,
    input  logic                       i_riscv_fdq_rst,
    input  logic                       i_riscv_fdq_flush,
    input  logic                       i_riscv_fdq_push_req,
    input  logic                       i_riscv_fdq_pop_req,
    output logic                       o_riscv_fdq_push,
    output logic                       o_riscv_fdq_pop,
    output logic [$clog2(DEPTH)-1:0]   o_riscv_fdq_wr_ptr,
    output logic [$clog2(DEPTH)-1:0]   o_riscv_fdq_rd_ptr,
    output logic [$clog2(DEPTH):0]     o_riscv_fdq_count,
    output logic                       o_riscv_fdq_full,
    output logic                       o_riscv_fdq_empty
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;

    // Status comes only from the registered count, so ready_f never has a
    // combinational path from ready_d: a full queue refuses a push even
    // when the head is popped in the same cycle.
    assign w_full  = (r_count == (c_ptr_w+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = i_riscv_fdq_push_req & ~w_full  & ~i_riscv_fdq_flush;
    assign w_pop   = i_riscv_fdq_pop_req  & ~w_empty & ~i_riscv_fdq_flush;

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge i_riscv_fdq_clk or posedge i_riscv_fdq_rst) begin
        if (i_riscv_fdq_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_riscv_fdq_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_riscv_fdq_push   = w_push;
    assign o_riscv_fdq_pop    = w_pop;
    assign o_riscv_fdq_wr_ptr = r_wr_ptr;
    assign o_riscv_fdq_rd_ptr = r_rd_ptr;
    assign o_riscv_fdq_count  = r_count;
    assign o_riscv_fdq_full   = w_full;
    assign o_riscv_fdq_empty  = w_empty;

endmodule
`default_nettype wire

// File: rtl/riscv_fd_iqueue.sv
`default_nettype none
// ============================================================================
// Module      : riscv_fd_iqueue
// Description : DEPTH-entry fetch-to-decode instruction queue with
//               valid/ready handshakes on both sides and a one-cycle flush.
// Ports       : i_riscv_fdq_clk / i_riscv_fdq_rst   clock, async reset
//               i_riscv_fdq_flush                   discard all entries
//               fetch side : valid_f, ready_f, pc_f, inst_f, pcplus4_f,
//                            cillegal_inst_f
//               decode side: valid_d, ready_d, pc_d, inst_d, pcplus4_d,
//                            cillegal_inst_d, rs1_d, constimm12_d
//               o_riscv_fdq_count                   occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_fd_iqueue
    import riscv_fdq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = XLEN_DEF,
    parameter int ILEN  = ILEN_DEF
) (
    input  logic                     i_riscv_fdq_clk,
    input  logic                     i_riscv_fdq_rst,
    input  logic                     i_riscv_fdq_flush,
    input  logic                     i_riscv_fdq_valid_f,
    output logic                     o_riscv_fdq_ready_f,
    input  logic [XLEN-1:0]          i_riscv_fdq_pc_f,
    input  logic [ILEN-1:0]          i_riscv_fdq_inst_f,
    input  logic [XLEN-1:0]          i_riscv_fdq_pcplus4_f,
    input  logic                     i_riscv_fdq_cillegal_inst_f,
    output logic                     o_riscv_fdq_valid_d,
    input  logic                     i_riscv_fdq_ready_d,
    output logic [XLEN-1:0]          o_riscv_fdq_pc_d,
    output logic [ILEN-1:0]          o_riscv_fdq_inst_d,
    output logic [XLEN-1:0]          o_riscv_fdq_pcplus4_d,
    output logic                     o_riscv_fdq_cillegal_inst_d,
    output logic [4:0]               o_riscv_fdq_rs1_d,
    output logic [11:0]              o_riscv_fdq_constimm12_d,
    output logic [$clog2(DEPTH):0]   o_riscv_fdq_count
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic               w_push;
    logic               w_pop;
    logic [c_ptr_w-1:0] w_wr_ptr;
    logic [c_ptr_w-1:0] w_rd_ptr;
    logic               w_full;
    logic               w_empty;
    fdq_entry_t         w_wr_entry;
    fdq_entry_t         w_head;
    fdq_entry_t         r_mem [DEPTH];

    riscv_fdq_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .i_riscv_fdq_clk      (i_riscv_fdq_clk),
        .i_riscv_fdq_rst      (i_riscv_fdq_rst),
        .i_riscv_fdq_flush    (i_riscv_fdq_flush),
        .i_riscv_fdq_push_req (i_riscv_fdq_valid_f),
        .i_riscv_fdq_pop_req  (i_riscv_fdq_ready_d),
        .o_riscv_fdq_push     (w_push),
        .o_riscv_fdq_pop      (w_pop),
        .o_riscv_fdq_wr_ptr   (w_wr_ptr),
        .o_riscv_fdq_rd_ptr   (w_rd_ptr),
        .o_riscv_fdq_count    (o_riscv_fdq_count),
        .o_riscv_fdq_full     (w_full),
        .o_riscv_fdq_empty    (w_empty)
    );

    always_comb begin
        w_wr_entry          = '0;
        w_wr_entry.pc       = i_riscv_fdq_pc_f;
        w_wr_entry.inst     = i_riscv_fdq_inst_f;
        w_wr_entry.pcplus4  = i_riscv_fdq_pcplus4_f;
        w_wr_entry.cillegal = i_riscv_fdq_cillegal_inst_f;
    end

    // Payload storage is deliberately not reset or flushed; the empty mask
    // below hides stale contents.
    always_ff @(posedge i_riscv_fdq_clk) begin
        if (w_push) begin
            r_mem[w_wr_ptr] <= w_wr_entry;
        end
    end

    // An empty queue presents an all-zero bubble (inst = 0), as the old
    // single-entry pipeline register did after a flush.
    always_comb begin
        w_head = r_mem[w_rd_ptr];
        if (w_empty) begin
            w_head = '0;
        end
    end

    assign o_riscv_fdq_ready_f         = ~w_full;
    assign o_riscv_fdq_valid_d         = ~w_empty;
    assign o_riscv_fdq_pc_d            = w_head.pc;
    assign o_riscv_fdq_inst_d          = w_head.inst;
    assign o_riscv_fdq_pcplus4_d       = w_head.pcplus4;
    assign o_riscv_fdq_cillegal_inst_d = w_head.cillegal;
    assign o_riscv_fdq_rs1_d           = w_head.inst[RS1_LSB +: 5];
    assign o_riscv_fdq_constimm12_d    = w_head.inst[IMM12_LSB +: 12];

endmodule
`default_nettype wire

// File: tb/tb_riscv_fd_iqueue.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_fd_iqueue
// Description : Directed self-checking bench for riscv_fd_iqueue (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_fd_iqueue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        valid_f;
    logic        ready_f;
    logic [63:0] pc_f;
    logic [31:0] inst_f;
    logic [63:0] pcplus4_f;
    logic        cill_f;
    logic        valid_d;
    logic        ready_d;
    logic [63:0] pc_d;
    logic [31:0] inst_d;
    logic [63:0] pcplus4_d;
    logic        cill_d;
    logic [4:0]  rs1_d;
    logic [11:0] imm_d;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    riscv_fd_iqueue #(
        .DEPTH (4),
        .XLEN  (64),
        .ILEN  (32)
    ) dut (
        .i_riscv_fdq_clk             (clk),
        .i_riscv_fdq_rst             (rst),
        .i_riscv_fdq_flush           (flush),
        .i_riscv_fdq_valid_f         (valid_f),
        .o_riscv_fdq_ready_f         (ready_f),
        .i_riscv_fdq_pc_f            (pc_f),
        .i_riscv_fdq_inst_f          (inst_f),
        .i_riscv_fdq_pcplus4_f       (pcplus4_f),
        .i_riscv_fdq_cillegal_inst_f (cill_f),
        .o_riscv_fdq_valid_d         (valid_d),
        .i_riscv_fdq_ready_d         (ready_d),
        .o_riscv_fdq_pc_d            (pc_d),
        .o_riscv_fdq_inst_d          (inst_d),
        .o_riscv_fdq_pcplus4_d       (pcplus4_d),
        .o_riscv_fdq_cillegal_inst_d (cill_d),
        .o_riscv_fdq_rs1_d           (rs1_d),
        .o_riscv_fdq_constimm12_d    (imm_d),
        .o_riscv_fdq_count           (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic v, input logic [63:0] pc,
                            input logic [31:0] inst, input logic cill);
        valid_f   = v;
        pc_f      = pc;
        inst_f    = inst;
        pcplus4_f = pc + 64'd4;
        cill_f    = cill;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; ready_d = 1'b0;
        set_push(1'b0, 64'h0, 32'h0, 1'b0);
        step(); step();
        rst = 1'b0;
        step(); step();
        n_checks++; if (count !== 3'd0)  begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL reset_valid_d: got %b want 0", valid_d); end
        n_checks++; if (ready_f !== 1'b1) begin n_fail++; $display("FAIL reset_ready_f: got %b want 1", ready_f); end
        n_checks++; if (inst_d !== 32'h0) begin n_fail++; $display("FAIL reset_inst_d: got %h want 0", inst_d); end
        n_checks++; if (pc_d !== 64'h0)   begin n_fail++; $display("FAIL reset_pc_d: got %h want 0", pc_d); end
        n_checks++; if (pcplus4_d !== 64'h0) begin n_fail++; $display("FAIL reset_pcplus4_d: got %h want 0", pcplus4_d); end
    endtask

    task automatic test_fill_drain();
        ready_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_push(1'b1, 64'h1000 + 64'(4*i), 32'h13 + 32'(i), 1'b0);
            step();
            if (i == 0) begin
                n_checks++; if (pc_d !== 64'h1000) begin n_fail++; $display("FAIL first_push_latency: pc_d %h want 1000", pc_d); end
            end
        end
        n_checks++; if (count !== 3'd4)   begin n_fail++; $display("FAIL full_count: got %0d want 4", count); end
        n_checks++; if (ready_f !== 1'b0) begin n_fail++; $display("FAIL full_ready_f: got %b want 0", ready_f); end
        // fifth push must be held while full
        set_push(1'b1, 64'h1010, 32'h17, 1'b0);
        step();
        n_checks++; if (count !== 3'd4)      begin n_fail++; $display("FAIL full_hold_count: got %0d want 4", count); end
        n_checks++; if (pc_d !== 64'h1000)   begin n_fail++; $display("FAIL full_hold_head: got %h want 1000", pc_d); end
        // pop with push pending: full queue refuses the push this cycle
        ready_d = 1'b1;
        step();
        n_checks++; if (count !== 3'd3)      begin n_fail++; $display("FAIL full_pop_count: got %0d want 3", count); end
        n_checks++; if (pc_d !== 64'h1004)   begin n_fail++; $display("FAIL drain_pc1: got %h want 1004", pc_d); end
        n_checks++; if (ready_f !== 1'b1)    begin n_fail++; $display("FAIL drain_ready_f: got %b want 1", ready_f); end
        step();
        set_push(1'b0, 64'h0, 32'h0, 1'b0);
        n_checks++; if (count !== 3'd3)      begin n_fail++; $display("FAIL pushpop_count: got %0d want 3", count); end
        n_checks++; if (pc_d !== 64'h1008)   begin n_fail++; $display("FAIL drain_pc2: got %h want 1008", pc_d); end
        step();
        n_checks++; if (pc_d !== 64'h100C)   begin n_fail++; $display("FAIL drain_pc3: got %h want 100c", pc_d); end
        n_checks++; if (pcplus4_d !== 64'h1010) begin n_fail++; $display("FAIL drain_pcplus4: got %h want 1010", pcplus4_d); end
        step();
        n_checks++; if (pc_d !== 64'h1010)   begin n_fail++; $display("FAIL drain_fifth: got %h want 1010", pc_d); end
        n_checks++; if (inst_d !== 32'h17)   begin n_fail++; $display("FAIL drain_fifth_inst: got %h want 17", inst_d); end
        step();
        n_checks++; if (count !== 3'd0)      begin n_fail++; $display("FAIL drained_count: got %0d want 0", count); end
        n_checks++; if (valid_d !== 1'b0)    begin n_fail++; $display("FAIL drained_valid: got %b want 0", valid_d); end
        n_checks++; if (inst_d !== 32'h0)    begin n_fail++; $display("FAIL drained_inst: got %h want 0", inst_d); end
        ready_d = 1'b0;
    endtask

    task automatic test_back_to_back();
        ready_d = 1'b0;
        set_push(1'b1, 64'h2000, 32'h1000_0013, 1'b0); step();
        set_push(1'b1, 64'h2004, 32'h1001_0013, 1'b0); step();
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_prefill: got %0d want 2", count); end
        ready_d = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_push(1'b1, 64'h2008 + 64'(4*i), 32'h1002_0013 + 32'(i << 16), 1'b0);
            step();
            n_checks++;
            if (count !== 3'd2 || valid_d !== 1'b1 || pc_d !== 64'h2004 + 64'(4*i)) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: count %0d valid %b pc %h want count 2 valid 1 pc %h",
                         i, count, valid_d, pc_d, 64'h2004 + 64'(4*i));
            end
        end
        set_push(1'b0, 64'h0, 32'h0, 1'b0);
        step();
        n_checks++; if (pc_d !== 64'h202C) begin n_fail++; $display("FAIL b2b_tail: got %h want 202c", pc_d); end
        step();
        n_checks++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b want 0", valid_d); end
        ready_d = 1'b0;
    endtask

    task automatic test_slices();
        ready_d = 1'b0;
        set_push(1'b1, 64'h3000, 32'h00C5_8533, 1'b0); step();
        n_checks++; if (rs1_d !== 5'h0B)   begin n_fail++; $display("FAIL rs1_slice: got %h want 0b", rs1_d); end
        n_checks++; if (imm_d !== 12'h00C) begin n_fail++; $display("FAIL imm12_slice: got %h want 00c", imm_d); end
        set_push(1'b1, 64'h3004, 32'h0000_0013, 1'b1); step();
        set_push(1'b1, 64'h3008, 32'h0000_0093, 1'b0); step();
        set_push(1'b0, 64'h0, 32'h0, 1'b0);
        n_checks++; if (cill_d !== 1'b0) begin n_fail++; $display("FAIL cill_entry0: got %b want 0", cill_d); end
        ready_d = 1'b1;
        step();
        n_checks++; if (cill_d !== 1'b1 || pc_d !== 64'h3004) begin n_fail++; $display("FAIL cill_entry1: cill %b pc %h want 1 3004", cill_d, pc_d); end
        step();
        n_checks++; if (cill_d !== 1'b0 || pc_d !== 64'h3008) begin n_fail++; $display("FAIL cill_entry2: cill %b pc %h want 0 3008", cill_d, pc_d); end
        step();
        ready_d = 1'b0;
    endtask

    task automatic test_flush();
        ready_d = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1, 64'h4000 + 64'(4*i), 32'h33 + 32'(i), 1'b0);
            step();
        end
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_prefill: got %0d want 3", count); end
        flush = 1'b1; ready_d = 1'b1;
        set_push(1'b1, 64'h400C, 32'h99, 1'b0);
        step();
        flush = 1'b0; ready_d = 1'b0;
        set_push(1'b0, 64'h0, 32'h0, 1'b0);
        n_checks++; if (count !== 3'd0)   begin n_fail++; $display("FAIL flush_count: got %0d want 0", count); end
        n_checks++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", valid_d); end
        n_checks++; if (pc_d !== 64'h0 || inst_d !== 32'h0) begin n_fail++; $display("FAIL flush_data: pc %h inst %h want 0 0", pc_d, inst_d); end
        n_checks++; if (ready_f !== 1'b1) begin n_fail++; $display("FAIL flush_ready_f: got %b want 1", ready_f); end
        set_push(1'b1, 64'h5000, 32'hAB, 1'b0); step();
        set_push(1'b0, 64'h0, 32'h0, 1'b0);
        n_checks++; if (count !== 3'd1 || pc_d !== 64'h5000) begin n_fail++; $display("FAIL post_flush_push: count %0d pc %h want 1 5000", count, pc_d); end
        ready_d = 1'b1;
        step();
        ready_d = 1'b0;
        n_checks++; if (valid_d !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL post_flush_only: valid %b count %0d want 0 0", valid_d, count); end
    endtask

    task automatic test_async_reset();
        ready_d = 1'b0;
        set_push(1'b1, 64'h6000, 32'h11, 1'b0); step();
        set_push(1'b1, 64'h6004, 32'h22, 1'b0); step();
        set_push(1'b0, 64'h0, 32'h0, 1'b0);
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL arst_prefill: got %0d want 2", count); end
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (count !== 3'd0 || valid_d !== 1'b0 || ready_f !== 1'b1 || pc_d !== 64'h0) begin
            n_fail++;
            $display("FAIL arst_immediate: count %0d valid %b ready %b pc %h want 0 0 1 0", count, valid_d, ready_f, pc_d);
        end
        #1;
        rst = 1'b0;
        set_push(1'b1, 64'h7000, 32'h33, 1'b0);
        step();
        set_push(1'b0, 64'h0, 32'h0, 1'b0);
        n_checks++;
        if (valid_d !== 1'b1 || pc_d !== 64'h7000 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL arst_first_push: valid %b pc %h count %0d want 1 7000 1", valid_d, pc_d, count);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_slices();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
